pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core; companion to the EX-stage operand forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use: 1-cycle stall plus bubble;
  - multi-cycle mul/div occupying EX: counter-driven freeze;
  - taken branch/jump resolved in EX: IF/ID and ID/EX flush.
- Drives the PC and pipeline-register enables, bubbles and flushes, and keeps a stall-cycle performance counter.

Parameters:
- MULDIV_LAT, 4: total cycles a mul/div instruction occupies EX; legal range 1..16.
- CNT_W, 4: width of the mul/div down-counter; must satisfy 2^CNT_W >= MULDIV_LAT.
- PERF_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- mem_read_ID_EX  in  1  instruction in EX is a load.
- rd_ID_EX  in  5  destination register of the instruction in EX.
- rs1_IF_ID  in  5  source register 1 of the instruction in ID.
- rs2_IF_ID  in  5  source register 2 of the instruction in ID.
- use_rs1_IF_ID  in  1  ID instruction actually reads rs1.
- use_rs2_IF_ID  in  1  ID instruction actually reads rs2.
- muldiv_ID_EX  in  1  instruction in EX is a mul/div.
- branch_taken_EX  in  1  taken branch/jump resolved in EX this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  load a NOP into ID/EX (control bits zeroed).
- ex_mem_bubble  out  1  load a NOP into EX/M.
- muldiv_busy  out  1  registered: FSM is in MD_BUSY.
- muldiv_done  out  1  mul/div result valid in EX this cycle.
- stall_cycles  out  PERF_W  saturating count of cycles with pc_write=0.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - FSM state=IDLE, counter=0, stall_cycles=0, muldiv_busy=0.
  - Combinational outputs forced to the defaults below while reset is asserted.
  - Reset asserted mid-mul/div abandons the operation; no muldiv_done is produced.
- Defaults: pc_write=1, if_id_write=1, id_ex_write=1; if_id_flush=0, id_ex_bubble=0, ex_mem_bubble=0, muldiv_done=0.
- load_use is true when all of the following hold:
  - mem_read_ID_EX=1;
  - rd_ID_EX != 0;
  - (use_rs1_IF_ID and rd_ID_EX==rs1_IF_ID) or (use_rs2_IF_ID and rd_ID_EX==rs2_IF_ID).
- State IDLE, priority order (first match wins):
  1. branch_taken_EX: if_id_flush=1, id_ex_bubble=1, pc_write=1. Stay IDLE. muldiv_ID_EX is ignored in this cycle.
  2. muldiv_ID_EX with MULDIV_LAT=1: muldiv_done=1, no stall. Stay IDLE.
  3. muldiv_ID_EX with MULDIV_LAT>1: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1. Load counter=MULDIV_LAT-2; go to MD_BUSY.
  4. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle. Stay IDLE.
- State MD_BUSY:
  - counter!=0: same hold outputs as IDLE case 3; counter decrements.
  - counter==0: muldiv_done=1, holds released (pipeline advances), next state IDLE. load_use is evaluated normally in this cycle and applies its stall/bubble.
  - branch_taken_EX and muldiv_ID_EX are ignored: EX holds the mul/div, and its input stays high while ID/EX is held.
  - load_use is suppressed while counter!=0.
- Net effect: a mul/div occupies EX for exactly MULDIV_LAT cycles, with MULDIV_LAT-1 freeze cycles.
- stall_cycles: increments by 1 on every clk edge where pc_write=0; saturates at all-ones; never wraps.
- All sequential state is updated on the rising clk edge; outputs are combinational from state and inputs, except muldiv_busy and stall_cycles.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum {IDLE, MD_BUSY};
  - constant REG_ZERO=5'd0;
  - default MULDIV_LAT.
- One natural sub-module, sat_counter: parameterised saturating up-counter with enable, used for stall_cycles.

Test Plan:
- Load-use: lw x5 in EX (mem_read=1, rd=5), ID reads rs2=5 with use_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all defaults; stall_cycles=1.
- Load to x0: rd_ID_EX=0 with matching rs1=0 -> no stall; all outputs at defaults.
- Mul/div (MULDIV_LAT=4): muldiv_ID_EX=1 -> three cycles of holds with ex_mem_bubble=1; muldiv_busy=1 in cycles 1-3; muldiv_done=1 in cycle 3; then IDLE; stall_cycles +3.
- Branch vs load-use: branch_taken_EX=1 while load_use is true -> if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall.
- Reset mid-op: arst_n driven low in cycle 2 of MD_BUSY -> immediately IDLE, muldiv_busy=0, stall_cycles=0, defaults on all outputs; no muldiv_done after release.
- Saturation: PERF_W=4 with 20 consecutive stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t         : mul/div sequencing FSM states
//   REG_ZERO        : architectural zero register index
//   MULDIV_LAT_DEF  : default mul/div occupancy of EX, in cycles
//   is_load_use()   : load-use hazard detection between EX and ID
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int unsigned MULDIV_LAT_DEF = 4;

  // A load in EX feeds a source that the ID instruction really reads; x0 never hazards.
  function automatic logic is_load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    logic hit1;
    logic hit2;
    hit1 = use_rs1 && (rd == rs1);
    hit2 = use_rs2 && (rd == rs2);
    return mem_read && (rd != REG_ZERO) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable.
//   clk, arst_n : clock, asynchronous active-low reset (clears count)
//   en          : increment request for this edge
//   count       : current value; sticks at all-ones, never wraps
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  // Count enabled edges until the ceiling is reached.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (en && (count != MAX_VAL)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: resolves the hazards forwarding cannot.
//   Inputs : EX-stage load/mul-div/branch status, rd of EX, rs1/rs2 (+use) of ID.
//   Outputs: PC / IF/ID / ID/EX enables, IF/ID flush, ID/EX and EX/M bubbles,
//            muldiv_done (combinational), muldiv_busy (registered),
//            stall_cycles (registered saturating count of pc_write=0 cycles).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              mem_read_ID_EX,
  input  logic [4:0]        rd_ID_EX,
  input  logic [4:0]        rs1_IF_ID,
  input  logic [4:0]        rs2_IF_ID,
  input  logic              use_rs1_IF_ID,
  input  logic              use_rs2_IF_ID,
  input  logic              muldiv_ID_EX,
  input  logic              branch_taken_EX,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              muldiv_busy,
  output logic              muldiv_done,
  output logic [PERF_W-1:0] stall_cycles
);

  // Single-cycle mul/div completes in place; longer ones freeze the front end.
  localparam bit               MD_MULTI = (MULDIV_LAT > 1);
  // The first freeze cycle is spent in IDLE, the last (done) cycle at count 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = MD_MULTI ? CNT_W'(int'(MULDIV_LAT) - 2) : '0;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_use;

  assign load_use = is_load_use(mem_read_ID_EX, rd_ID_EX, rs1_IF_ID, rs2_IF_ID,
                                use_rs1_IF_ID, use_rs2_IF_ID);

  // FSM state, countdown and busy flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      muldiv_busy <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      muldiv_busy <= (state_d == MD_BUSY);
    end
  end

  // Next state and pipeline control; held at defaults while reset is asserted.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    muldiv_done   = 1'b0;

    if (arst_n) begin
      unique case (state_q)
        IDLE: begin
          if (branch_taken_EX) begin
            // Squash the two wrong-path instructions behind the branch.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (muldiv_ID_EX) begin
            if (!MD_MULTI) begin
              muldiv_done = 1'b1;
            end else begin
              pc_write      = 1'b0;
              if_id_write   = 1'b0;
              id_ex_write   = 1'b0;
              ex_mem_bubble = 1'b1;
              cnt_d         = CNT_LOAD;
              state_d       = MD_BUSY;
            end
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end

        MD_BUSY: begin
          // EX owns the mul/div here, so branch and muldiv inputs are stale.
          if (cnt_q != '0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt_q - CNT_W'(1);
          end else begin
            muldiv_done = 1'b1;
            state_d     = IDLE;
            if (load_use) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Performance counter: cycles in which the PC was held.
  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (!pc_write),
    .count  (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controllers (MULDIV_LAT=4/PERF_W=16 and
// MULDIV_LAT=1/PERF_W=4) share stimulus and are checked against a
// cycle-occupancy reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       mem_read_ID_EX = 1'b0;
  logic [4:0] rd_ID_EX = '0;
  logic [4:0] rs1_IF_ID = '0;
  logic [4:0] rs2_IF_ID = '0;
  logic       use_rs1_IF_ID = 1'b0;
  logic       use_rs2_IF_ID = 1'b0;
  logic       muldiv_ID_EX = 1'b0;
  logic       branch_taken_EX = 1'b0;

  logic        pcw_a, ifw_a, flush_a, idw_a, idb_a, exb_a, busy_a, done_a;
  logic [15:0] stall_a;
  logic        pcw_b, ifw_b, flush_b, idw_b, idb_b, exb_b, busy_b, done_b;
  logic [3:0]  stall_b;

  int tests = 0;
  int fails = 0;

  // Reference model state: EX cycles the mul/div still owns, stall tallies.
  int md_left_a = 0, md_left_b = 0;
  int cnt_a = 0, cnt_b = 0;

  logic [23:0] exp_a, got_a;
  logic [11:0] exp_b, got_b;

  localparam logic [7:0] CTRL_DEF = 8'b1101_0000;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4), .PERF_W(16)) dut_a (
    .clk(clk), .arst_n(arst_n),
    .mem_read_ID_EX(mem_read_ID_EX), .rd_ID_EX(rd_ID_EX),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .use_rs1_IF_ID(use_rs1_IF_ID), .use_rs2_IF_ID(use_rs2_IF_ID),
    .muldiv_ID_EX(muldiv_ID_EX), .branch_taken_EX(branch_taken_EX),
    .pc_write(pcw_a), .if_id_write(ifw_a), .if_id_flush(flush_a),
    .id_ex_write(idw_a), .id_ex_bubble(idb_a), .ex_mem_bubble(exb_a),
    .muldiv_busy(busy_a), .muldiv_done(done_a), .stall_cycles(stall_a)
  );

  pipeline_hazard_ctrl #(.MULDIV_LAT(1), .CNT_W(4), .PERF_W(4)) dut_b (
    .clk(clk), .arst_n(arst_n),
    .mem_read_ID_EX(mem_read_ID_EX), .rd_ID_EX(rd_ID_EX),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .use_rs1_IF_ID(use_rs1_IF_ID), .use_rs2_IF_ID(use_rs2_IF_ID),
    .muldiv_ID_EX(muldiv_ID_EX), .branch_taken_EX(branch_taken_EX),
    .pc_write(pcw_b), .if_id_write(ifw_b), .if_id_flush(flush_b),
    .id_ex_write(idw_b), .id_ex_bubble(idb_b), .ex_mem_bubble(exb_b),
    .muldiv_busy(busy_b), .muldiv_done(done_b), .stall_cycles(stall_b)
  );

  // One cycle of the reference behaviour; ctrl = {pcw,ifw,flush,idw,idb,exb,busy,done}.
  task automatic model_step(input int lat, input int maxv, input logic lu,
                            input logic br, input logic md,
                            inout int md_left, inout int stall,
                            output logic [7:0] ctrl, output int stall_now);
    logic pcw, ifw, flush, idw, idb, exb, busy, done;
    stall_now = stall;
    pcw = 1; ifw = 1; flush = 0; idw = 1; idb = 0; exb = 0; done = 0;
    busy = (md_left > 0);
    if (md_left > 1) begin
      pcw = 0; ifw = 0; idw = 0; exb = 1;
      md_left--;
    end else if (md_left == 1) begin
      done = 1;
      md_left = 0;
      if (lu) begin pcw = 0; ifw = 0; idb = 1; end
    end else if (br) begin
      flush = 1; idb = 1;
    end else if (md) begin
      if (lat == 1) done = 1;
      else begin
        pcw = 0; ifw = 0; idw = 0; exb = 1;
        md_left = lat - 1;
      end
    end else if (lu) begin
      pcw = 0; ifw = 0; idb = 1;
    end
    if (!pcw && stall < maxv) stall++;
    ctrl = {pcw, ifw, flush, idw, idb, exb, busy, done};
  endtask

  task automatic sample_dut();
    got_a = {pcw_a, ifw_a, flush_a, idw_a, idb_a, exb_a, busy_a, done_a, stall_a};
    got_b = {pcw_b, ifw_b, flush_b, idw_b, idb_b, exb_b, busy_b, done_b, stall_b};
  endtask

  // Drive one cycle of inputs and compute the expected response of both DUTs.
  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic md, input logic br);
    logic lu;
    logic [7:0] ca, cb;
    int sa, sb;
    @(negedge clk);
    mem_read_ID_EX = mr; rd_ID_EX = rd; rs1_IF_ID = rs1; rs2_IF_ID = rs2;
    use_rs1_IF_ID = u1; use_rs2_IF_ID = u2; muldiv_ID_EX = md; branch_taken_EX = br;
    #1;
    lu = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    model_step(4, 65535, lu, br, md, md_left_a, cnt_a, ca, sa);
    model_step(1, 15, lu, br, md, md_left_b, cnt_b, cb, sb);
    exp_a = {ca, 16'(sa)};
    exp_b = {cb, 4'(sb)};
    sample_dut();
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    md_left_a = 0; md_left_b = 0; cnt_a = 0; cnt_b = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    arst_n = 1'b0;
    mem_read_ID_EX = 0; rd_ID_EX = '0; rs1_IF_ID = '0; rs2_IF_ID = '0;
    use_rs1_IF_ID = 0; use_rs2_IF_ID = 0; muldiv_ID_EX = 0; branch_taken_EX = 0;
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Hazard-looking inputs while reset is held must still give defaults.
    arst_n = 1'b0;
    mem_read_ID_EX = 1; rd_ID_EX = 5'd3; rs1_IF_ID = 5'd3; use_rs1_IF_ID = 1;
    muldiv_ID_EX = 1; branch_taken_EX = 0;
    #12;
    sample_dut();
    tests++;
    if (got_a !== {CTRL_DEF, 16'h0}) begin
      fails++; $display("FAIL reset_a got=%h exp=%h", got_a, {CTRL_DEF, 16'h0});
    end
    tests++;
    if (got_b !== {CTRL_DEF, 4'h0}) begin
      fails++; $display("FAIL reset_b got=%h exp=%h", got_b, {CTRL_DEF, 4'h0});
    end
    model_reset();
    apply_reset();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b1, 5'd5, 5'd7, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      else        idle_step();
      tests++;
      if (got_a !== exp_a) begin fails++; $display("FAIL load_use_a[%0d] got=%h exp=%h", i, got_a, exp_a); end
      tests++;
      if (got_b !== exp_b) begin fails++; $display("FAIL load_use_b[%0d] got=%h exp=%h", i, got_b, exp_b); end
    end
    tests++;
    if (stall_a !== 16'd1) begin fails++; $display("FAIL load_use_stall got=%0d exp=1", stall_a); end
  endtask

  task automatic test_load_x0();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tests++;
      if (got_a[23:16] !== CTRL_DEF) begin fails++; $display("FAIL load_x0[%0d] got=%h exp=%h", i, got_a[23:16], CTRL_DEF); end
      tests++;
      if (got_a !== exp_a) begin fails++; $display("FAIL load_x0_model[%0d] got=%h exp=%h", i, got_a, exp_a); end
    end
  endtask

  task automatic test_muldiv();
    apply_reset();
    // Mul/div input stays high while ID/EX is held, drops once EX moves on.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i < 4), 1'b0);
      tests++;
      if (got_a !== exp_a) begin fails++; $display("FAIL muldiv_a[%0d] got=%h exp=%h", i, got_a, exp_a); end
      tests++;
      if (got_b !== exp_b) begin fails++; $display("FAIL muldiv_b[%0d] got=%h exp=%h", i, got_b, exp_b); end
    end
    tests++;
    if (stall_a !== 16'd3) begin fails++; $display("FAIL muldiv_stall got=%0d exp=3", stall_a); end
  endtask

  task automatic test_muldiv_done_load_use();
    // Load-use presented on the mul/div completion cycle still stalls.
    for (int i = 0; i < 6; i++) begin
      if (i == 3) step(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      else        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i < 4), (i == 1));
      tests++;
      if (got_a !== exp_a) begin fails++; $display("FAIL md_done_lu_a[%0d] got=%h exp=%h", i, got_a, exp_a); end
      tests++;
      if (got_b !== exp_b) begin fails++; $display("FAIL md_done_lu_b[%0d] got=%h exp=%h", i, got_b, exp_b); end
    end
  endtask

  task automatic test_branch_vs_load_use();
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tests++;
    if ({pcw_a, flush_a, idb_a, ifw_a} !== 4'b1111) begin
      fails++; $display("FAIL branch_lu got=%b exp=1111", {pcw_a, flush_a, idb_a, ifw_a});
    end
    tests++;
    if (got_a !== exp_a) begin fails++; $display("FAIL branch_lu_a got=%h exp=%h", got_a, exp_a); end
    tests++;
    if (got_b !== exp_b) begin fails++; $display("FAIL branch_lu_b got=%h exp=%h", got_b, exp_b); end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    sample_dut();
    tests++;
    if (got_a !== {CTRL_DEF, 16'h0}) begin
      fails++; $display("FAIL reset_mid_a got=%h exp=%h", got_a, {CTRL_DEF, 16'h0});
    end
    tests++;
    if (got_b !== {CTRL_DEF, 4'h0}) begin
      fails++; $display("FAIL reset_mid_b got=%h exp=%h", got_b, {CTRL_DEF, 4'h0});
    end
    model_reset();
    @(negedge clk);
    muldiv_ID_EX = 1'b0;
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_step();
      tests++;
      if (got_a !== exp_a) begin fails++; $display("FAIL reset_mid_after[%0d] got=%h exp=%h", i, got_a, exp_a); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      if (i < 20) step(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      else        idle_step();
      tests++;
      if (got_b !== exp_b) begin fails++; $display("FAIL sat_b[%0d] got=%h exp=%h", i, got_b, exp_b); end
    end
    tests++;
    if (stall_b !== 4'd15) begin fails++; $display("FAIL sat_hold got=%0d exp=15", stall_b); end
    tests++;
    if (stall_a !== 16'd20) begin fails++; $display("FAIL sat_wide got=%0d exp=20", stall_a); end
  endtask

  task automatic test_random();
    logic [4:0] rd, rs1, rs2;
    logic mr, u1, u2, md, br;
    for (int i = 0; i < 400; i++) begin
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      mr  = ($urandom_range(0, 1) == 1);
      u1  = ($urandom_range(0, 3) != 0);
      u2  = ($urandom_range(0, 1) == 1);
      md  = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 7) == 0);
      step(mr, rd, rs1, rs2, u1, u2, md, br);
      tests++;
      if (got_a !== exp_a) begin fails++; $display("FAIL random_a[%0d] got=%h exp=%h", i, got_a, exp_a); end
      tests++;
      if (got_b !== exp_b) begin fails++; $display("FAIL random_b[%0d] got=%h exp=%h", i, got_b, exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_x0();
    test_muldiv();
    test_muldiv_done_load_use();
    test_branch_vs_load_use();
    test_reset_mid_op();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
